// File: rtl/seg_display_scan_if.sv
// Scan-display bus: digit index, value/decimal-point inputs and load strobe in;
// registered anode/segment/dp drive and frame marker out.
interface seg_display_scan_if #(
  parameter int N = 2
);
  localparam int D = 2 ** N;

  logic [N-1:0]   digit_sel;
  logic [4*D-1:0] data_in;
  logic [D-1:0]   dp_in;
  logic           load;
  logic           blank_lz;
  logic [D-1:0]   an;
  logic [6:0]     seg;
  logic           dp;
  logic           frame_start;

  modport master (
    output digit_sel, data_in, dp_in, load, blank_lz,
    input  an, seg, dp, frame_start
  );

  modport slave (
    input  digit_sel, data_in, dp_in, load, blank_lz,
    output an, seg, dp, frame_start
  );
endinterface

// File: rtl/seg_display_scan.sv
// Multiplexed 7-segment driver: double-buffered hex value, dead-time blanking after
// every digit change, leading-zero suppression; all outputs registered.
module seg_display_scan #(
  parameter int N         = 2,
  parameter int BLANK_CYC = 16
) (
  input  logic                clk,
  input  logic                reset,
  seg_display_scan_if.slave   scan_io
);
  localparam int D  = 2 ** N;
  localparam int CW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   sel_q, sel_d;
  logic [4*D-1:0] shadow_q, shadow_d, disp_q, disp_d;
  logic [D-1:0]   shdp_q, shdp_d, dpreg_q, dpreg_d;
  logic [D-1:0]   an_q, an_d;
  logic [6:0]     seg_q, seg_d;
  logic           dp_q, dp_d, fs_q, fs_d;
  logic           chg;
  logic [4*D-1:0] upper;
  logic [3:0]     nib;
  logic           suppress;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h3F; 4'h1: glyph = 7'h06; 4'h2: glyph = 7'h5B; 4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66; 4'h5: glyph = 7'h6D; 4'h6: glyph = 7'h7D; 4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F; 4'h9: glyph = 7'h6F; 4'hA: glyph = 7'h77; 4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39; 4'hD: glyph = 7'h5E; 4'hE: glyph = 7'h79; default: glyph = 7'h71;
    endcase
  endfunction

  assign chg = (scan_io.digit_sel != sel_q);

  always_comb begin
    sel_d    = scan_io.digit_sel;
    shadow_d = scan_io.load ? scan_io.data_in : shadow_q;
    shdp_d   = scan_io.load ? scan_io.dp_in   : shdp_q;
    disp_d   = disp_q;
    dpreg_d  = dpreg_q;
    fs_d     = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    an_d     = '1;
    seg_d    = 7'h7F;
    dp_d     = 1'b1;

    // Wrap to digit 0: promote the shadow as it stood before this edge.
    if (chg && scan_io.digit_sel == '0) begin
      disp_d  = shadow_q;
      dpreg_d = shdp_q;
      fs_d    = 1'b1;
    end

    if (chg) begin
      if (BLANK_CYC > 0) begin
        state_d = BLANK;
        cnt_d   = CNT_INIT;
      end else begin
        state_d = DRIVE;
      end
    end else if (state_q == BLANK) begin
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      else             state_d = DRIVE;
    end

    // Decode from post-edge selection so a zero-dead-time build shows the new digit immediately.
    upper    = disp_d >> (4 * sel_d);
    nib      = upper[3:0];
    suppress = scan_io.blank_lz && (sel_d != '0) && (upper == '0);

    if (state_d == DRIVE) begin
      an_d  = ~(D'(1) << sel_d);
      seg_d = suppress ? 7'h7F : ~glyph(nib);
      dp_d  = ~dpreg_d[sel_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= BLANK;
      cnt_q    <= CNT_INIT;
      sel_q    <= '0;
      shadow_q <= '0;
      shdp_q   <= '0;
      disp_q   <= '0;
      dpreg_q  <= '0;
      an_q     <= '1;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      shdp_q   <= shdp_d;
      disp_q   <= disp_d;
      dpreg_q  <= dpreg_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      fs_q     <= fs_d;
    end
  end

  assign scan_io.an          = an_q;
  assign scan_io.seg         = seg_q;
  assign scan_io.dp          = dp_q;
  assign scan_io.frame_start = fs_q;
endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan: a 16-cycle dead-time instance and a zero dead-time instance
// driven in parallel, checked against an edge-counting reference model.
module tb_seg_display_scan;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg_display_scan_if #(.N(2)) bi ();
  seg_display_scan_if #(.N(2)) b0 ();

  seg_display_scan #(.N(2), .BLANK_CYC(16)) u_dut  (.clk(clk), .reset(reset), .scan_io(bi.slave));
  seg_display_scan #(.N(2), .BLANK_CYC(0))  u_dut0 (.clk(clk), .reset(reset), .scan_io(b0.slave));

  logic [1:0]  sel;
  logic [15:0] data;
  logic [3:0]  dpi;
  logic        ld, lz;

  assign bi.digit_sel = sel;  assign b0.digit_sel = sel;
  assign bi.data_in   = data; assign b0.data_in   = data;
  assign bi.dp_in     = dpi;  assign b0.dp_in     = dpi;
  assign bi.load      = ld;   assign b0.load      = ld;
  assign bi.blank_lz  = lz;   assign b0.blank_lz  = lz;

  logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: value pipeline plus edges elapsed since the last digit change.
  logic [1:0]  m_sel;
  logic [15:0] m_shadow, m_disp;
  logic [3:0]  m_shdp, m_dpd;
  int          since;
  bit          fresh, m_fs;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic chk_dut(input string tag, input logic [3:0] an_a, input logic [6:0] seg_a,
                         input logic dp_a, input logic fs_a, input bit dark);
    logic [3:0]  ean;
    logic [6:0]  eseg;
    logic        edp;
    logic [15:0] upper;
    ean = 4'hF; eseg = 7'h7F; edp = 1'b1;
    if (!dark) begin
      ean   = ~(4'b0001 << m_sel);
      upper = m_disp >> (4 * m_sel);
      eseg  = (lz && m_sel != 2'd0 && upper == 16'h0) ? 7'h7F : ~GLYPH[upper[3:0]];
      edp   = ~m_dpd[m_sel];
    end
    chk({tag, ".an"},  16'(an_a),  16'(ean));
    chk({tag, ".seg"}, 16'(seg_a), 16'(eseg));
    chk({tag, ".dp"},  16'(dp_a),  16'(edp));
    chk({tag, ".fs"},  16'(fs_a),  16'(m_fs));
  endtask

  task automatic check_both();
    chk_dut("bc16", bi.an, bi.seg, bi.dp, bi.frame_start, fresh || since < 16);
    chk_dut("bc0",  b0.an, b0.seg, b0.dp, b0.frame_start, fresh);
  endtask

  task automatic model_reset();
    m_sel = 2'd0; m_shadow = 16'h0; m_disp = 16'h0; m_shdp = 4'h0; m_dpd = 4'h0;
    since = 0; fresh = 1'b1; m_fs = 1'b0;
  endtask

  task automatic step();
    bit c;
    @(posedge clk);
    c = (sel != m_sel);
    if (c) since = 0;
    else if (since < 1000) since++;
    m_fs = c && (sel == 2'd0);
    if (m_fs) begin
      m_disp = m_shadow;
      m_dpd  = m_shdp;
    end
    if (ld) begin
      m_shadow = data;
      m_shdp   = dpi;
    end
    m_sel = sel;
    fresh = 1'b0;
    #1;
    check_both();
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    data = v; dpi = d; ld = 1'b1;
    step();
    ld = 1'b0;
  endtask

  task automatic scan_to(input logic [1:0] s, input int n);
    sel = s;
    hold(n);
  endtask

  initial begin
    sel = 2'd0; data = 16'h0; dpi = 4'h0; ld = 1'b0; lz = 1'b0;
    reset = 1'b1;
    model_reset();
    #12;
    check_both();
    chk("rst.an", 16'(bi.an), 16'h000F);
    @(negedge clk) reset = 1'b0;

    // Power-up: dark for the dead time, then digit 0 shows '0'.
    hold(20);
    chk("pwrup.seg", 16'(bi.seg), 16'h0040);

    // Load 1234 and scan one frame; the wrap promotes it.
    do_load(16'h1234, 4'h0);
    scan_to(2'd1, 20); scan_to(2'd2, 20); scan_to(2'd3, 20);
    sel = 2'd0;
    step();
    chk("wrap.fs", 16'(bi.frame_start), 16'h0001);
    step();
    chk("wrap.fs_pulse", 16'(bi.frame_start), 16'h0000);
    hold(14);
    chk("wrap.dark", 16'(bi.an), 16'h000F);
    step();
    chk("wrap.an", 16'(bi.an), 16'h000E);
    chk("wrap.seg", 16'(bi.seg), 16'h0019);

    // A mid-frame load must not disturb the digits still being shown.
    scan_to(2'd1, 3);
    do_load(16'h5678, 4'h0);
    hold(16);
    chk("dbuf.d1", 16'(bi.seg), 16'h0030);
    scan_to(2'd2, 20); scan_to(2'd3, 20);
    chk("dbuf.d3", 16'(bi.seg), 16'h0079);
    scan_to(2'd0, 20);
    chk("dbuf.d0", 16'(bi.seg), 16'h0000);

    // Leading-zero suppression.
    lz = 1'b1;
    do_load(16'h0007, 4'h0);
    scan_to(2'd1, 20); scan_to(2'd2, 20); scan_to(2'd3, 20); scan_to(2'd0, 20);
    chk("lz.d0", 16'(bi.seg), 16'h0078);
    scan_to(2'd3, 20);
    chk("lz.d3", 16'(bi.seg), 16'h007F);
    chk("lz.d3an", 16'(bi.an), 16'h0007);
    do_load(16'h0000, 4'h0);
    scan_to(2'd0, 20);
    chk("lz.zero", 16'(bi.seg), 16'h0040);
    lz = 1'b0;

    // A second change during dead time restarts the count.
    scan_to(2'd1, 5);
    scan_to(2'd2, 16);
    chk("restart.dark", 16'(bi.an), 16'h000F);
    step();
    chk("restart.an", 16'(bi.an), 16'h000B);

    // Zero dead-time build drives the new digit on the change edge.
    scan_to(2'd0, 20);
    sel = 2'd1;
    step();
    chk("bc0.an", 16'(b0.an), 16'h000D);

    // Randomized scanning, loads, decimal points and suppression.
    for (int i = 0; i < 400; i++) begin
      int n;
      sel = 2'($urandom_range(0, 3));
      lz  = 1'($urandom_range(0, 1));
      n   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 16) : $urandom_range(17, 24);
      for (int j = 0; j < n; j++) begin
        ld = ($urandom_range(0, 5) == 0);
        if (ld) begin
          data = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
          dpi  = 4'($urandom);
        end
        step();
      end
      ld = 1'b0;
    end

    // Asynchronous reset pulse while driving.
    scan_to(sel, 20);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_both();
    @(negedge clk) reset = 1'b0;
    sel = 2'd0;
    hold(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
